// File: rtl/deser_pkg.sv
// Shared types for the deserializer path: byte type, enqueue handshake states, default queue depth.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package deser_pkg;

    typedef logic [7:0] byte_t;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        ACK      = 2'd1,
        WAIT_LOW = 2'd2
    } enq_state_t;

    localparam int QUEUE_DEPTH_DEFAULT = 8;

endpackage

// File: rtl/byte_queue_ram.sv
// DEPTH x 8 storage array for byte_queue: synchronous write, combinational read by index.
// Latency: write visible on rd_data the cycle after the write edge; read is combinational.
// Backpressure: none; the caller guarantees it only writes free entries.
//
// Ports: clock_100k; wr_en/wr_idx/wr_data write port; rd_idx/rd_data read port.
// The array has no reset: contents are don't-care until written.
module byte_queue_ram
    import deser_pkg::*;
#(
    parameter int DEPTH = QUEUE_DEPTH_DEFAULT,
    parameter int PTR_W = $clog2(DEPTH)
) (
    input  logic             clock_100k,
    input  logic             wr_en,
    input  logic [PTR_W-1:0] wr_idx,
    input  logic [7:0]       wr_data,
    input  logic [PTR_W-1:0] rd_idx,
    output logic [7:0]       rd_data
);

    byte_t mem [DEPTH];

    always_ff @(posedge clock_100k) begin
        if (wr_en) begin
            mem[wr_idx] <= wr_data;
        end
    end

    assign rd_data = mem[rd_idx];

endmodule

// File: rtl/byte_queue.sv
// Circular byte FIFO behind the deserializer, with an ack handshake on the write side and a pop-pulse read side.
// Latency: write at the edge enqueue_in is seen in IDLE, ack_out the following cycle; popped byte registered one edge after dequeue_in.
// Backpressure: when full the ack is withheld (deserializer stalls); a pop on empty is ignored.
//
// Ports: clock_100k, reset (async, active-high); data_in/enqueue_in/ack_out to the deserializer;
// dequeue_in/data_out/valid_out to the consumer; len_out/full_out/empty_out occupancy status.
module byte_queue
    import deser_pkg::*;
#(
    parameter int DEPTH = QUEUE_DEPTH_DEFAULT,
    parameter int LEN_W = $clog2(DEPTH) + 1
) (
    input  logic             clock_100k,
    input  logic             reset,
    input  logic [7:0]       data_in,
    input  logic             enqueue_in,
    output logic             ack_out,
    input  logic             dequeue_in,
    output logic [7:0]       data_out,
    output logic             valid_out,
    output logic [LEN_W-1:0] len_out,
    output logic             full_out,
    output logic             empty_out
);

    localparam int PTR_W = $clog2(DEPTH);

    enq_state_t       state;
    enq_state_t       state_next;
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             wr_en;
    logic             rd_en;
    logic [7:0]       rd_data;
    logic [LEN_W-1:0] len_next;

    byte_queue_ram #(
        .DEPTH (DEPTH),
        .PTR_W (PTR_W)
    ) u_ram (
        .clock_100k (clock_100k),
        .wr_en      (wr_en),
        .wr_idx     (wr_ptr),
        .wr_data    (data_in),
        .rd_idx     (rd_ptr),
        .rd_data    (rd_data)
    );

    // Enqueue handshake FSM: state register.
    always_ff @(posedge clock_100k or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next state. WAIT_LOW holds until data_ready drops so a byte held
    // high for many cycles is still written only once.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:     if (enqueue_in && !full_out) state_next = ACK;
            ACK:      state_next = WAIT_LOW;
            WAIT_LOW: if (!enqueue_in) state_next = IDLE;
            default:  state_next = IDLE;
        endcase
    end

    // Outputs. ack_out decodes straight from the state register, so an
    // async reset during ACK drops it immediately and the byte is retaken.
    always_comb begin
        ack_out = 1'b0;
        wr_en   = 1'b0;
        case (state)
            IDLE:    wr_en   = enqueue_in && !full_out;
            ACK:     ack_out = 1'b1;
            default: ;
        endcase
    end

    // Registered flags gate both sides: a pop on the write edge of an
    // empty queue, or a write on the pop edge of a full queue, is refused.
    assign rd_en = dequeue_in && !empty_out;

    always_comb begin
        len_next = len_out;
        if (wr_en && !rd_en) begin
            len_next = len_out + 1'b1;
        end else if (rd_en && !wr_en) begin
            len_next = len_out - 1'b1;
        end
    end

    // Pointers wrap naturally (DEPTH is a power of two); full/empty come
    // from the occupancy count, not pointer comparison.
    always_ff @(posedge clock_100k or posedge reset) begin
        if (reset) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            len_out   <= '0;
            full_out  <= 1'b0;
            empty_out <= 1'b1;
            data_out  <= 8'h00;
            valid_out <= 1'b0;
        end else begin
            if (wr_en) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (rd_en) begin
                rd_ptr   <= rd_ptr + 1'b1;
                data_out <= rd_data;
            end
            valid_out <= rd_en;
            len_out   <= len_next;
            full_out  <= (len_next == LEN_W'(DEPTH));
            empty_out <= (len_next == '0);
        end
    end

endmodule

// File: tb/tb_byte_queue.sv
// Self-checking bench for byte_queue: directed handshake/full/empty/wrap/reset scenarios plus random traffic.
// Latency: n/a (testbench).
// Backpressure: the deserializer emulation holds enqueue_in until ack_out, then drops it.
module tb_byte_queue;
    import deser_pkg::*;

    localparam int DEPTH = 8;
    localparam int LEN_W = $clog2(DEPTH) + 1;

    logic             clock_100k = 1'b0;
    logic             reset      = 1'b1;
    logic [7:0]       data_in    = 8'h00;
    logic             enqueue_in = 1'b0;
    logic             dequeue_in = 1'b0;
    logic             ack_out;
    logic [7:0]       data_out;
    logic             valid_out;
    logic [LEN_W-1:0] len_out;
    logic             full_out;
    logic             empty_out;

    int checks   = 0;
    int failures = 0;
    bit mon_en   = 1'b0;

    byte_queue #(.DEPTH(DEPTH), .LEN_W(LEN_W)) dut (
        .clock_100k (clock_100k),
        .reset      (reset),
        .data_in    (data_in),
        .enqueue_in (enqueue_in),
        .ack_out    (ack_out),
        .dequeue_in (dequeue_in),
        .data_out   (data_out),
        .valid_out  (valid_out),
        .len_out    (len_out),
        .full_out   (full_out),
        .empty_out  (empty_out)
    );

    always #5 clock_100k = ~clock_100k;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: a byte list plus the handshake rule "one byte per
    // data_ready assertion, ack the cycle after acceptance, then wait for
    // data_ready to drop". Occupancy and flags are read off the list size.
    byte_t m_q[$];
    bit    m_ack_due  = 1'b0;
    bit    m_wait_drop = 1'b0;
    byte_t m_data     = 8'h00;
    bit    m_valid    = 1'b0;
    bit    m_take;
    bit    m_pop;

    always begin
        @(posedge clock_100k or posedge reset);
        if (reset) begin
            m_q.delete();
            m_ack_due   = 1'b0;
            m_wait_drop = 1'b0;
            m_data      = 8'h00;
            m_valid     = 1'b0;
        end else begin
            m_take  = enqueue_in && !m_ack_due && !m_wait_drop && (m_q.size() < DEPTH);
            m_pop   = dequeue_in && (m_q.size() > 0);
            m_valid = m_pop;
            if (m_pop) m_data = m_q.pop_front();
            if (m_ack_due) begin
                m_ack_due   = 1'b0;
                m_wait_drop = 1'b1;
            end else if (m_wait_drop && !enqueue_in) begin
                m_wait_drop = 1'b0;
            end
            if (m_take) begin
                m_q.push_back(data_in);
                m_ack_due = 1'b1;
            end
        end
    end

    always begin
        @(negedge clock_100k);
        if (mon_en) begin
            check_eq("mon_ack",   ack_out,   m_ack_due);
            check_eq("mon_valid", valid_out, m_valid);
            check_eq("mon_data",  data_out,  m_data);
            check_eq("mon_len",   len_out,   m_q.size());
            check_eq("mon_full",  full_out,  m_q.size() == DEPTH);
            check_eq("mon_empty", empty_out, m_q.size() == 0);
        end
    end

    // Present a byte, wait (bounded) for the ack, hold extra cycles, drop and
    // stay low long enough for the handshake to return to idle.
    task automatic send_byte(input byte_t b, input int extra_hold);
        bit acked = 1'b0;
        int extra_acks = 0;
        data_in    = b;
        enqueue_in = 1'b1;
        for (int i = 0; i < 40 && !acked; i++) begin
            @(negedge clock_100k);
            if (ack_out) acked = 1'b1;
        end
        check_eq("ack_seen", acked, 1);
        for (int i = 0; i < extra_hold; i++) begin
            @(negedge clock_100k);
            if (ack_out) extra_acks++;
        end
        enqueue_in = 1'b0;
        repeat (2) begin
            @(negedge clock_100k);
            if (ack_out) extra_acks++;
        end
        check_eq("ack_once", extra_acks, 0);
    endtask

    task automatic drain_all();
        for (int i = 0; i < 3 * DEPTH && len_out != 0; i++) begin
            dequeue_in = 1'b1;
            @(negedge clock_100k);
        end
        dequeue_in = 1'b0;
        check_eq("drain_len", len_out, 0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int    n_ack;
        int    gap;
        int    hold;
        bit    acked;
        byte_t exp_b;

        repeat (2) @(negedge clock_100k);
        check_eq("rst_len",   len_out,   0);
        check_eq("rst_empty", empty_out, 1);
        check_eq("rst_full",  full_out,  0);
        check_eq("rst_ack",   ack_out,   0);
        check_eq("rst_data",  data_out,  8'h00);
        check_eq("rst_valid", valid_out, 0);
        reset  = 1'b0;
        mon_en = 1'b1;

        // Single byte held 3 extra cycles after the ack: one write only.
        send_byte(8'hAD, 3);
        check_eq("ad_len",   len_out,   1);
        check_eq("ad_empty", empty_out, 0);
        dequeue_in = 1'b1;
        @(negedge clock_100k);
        dequeue_in = 1'b0;
        check_eq("ad_pop", data_out, 8'hAD);

        // Fill to full.
        for (int i = 1; i <= DEPTH; i++) send_byte(byte_t'(i), 0);
        check_eq("fill_full", full_out, 1);
        check_eq("fill_len",  len_out,  DEPTH);

        // Ninth byte stalls while full.
        data_in    = 8'h09;
        enqueue_in = 1'b1;
        n_ack = 0;
        repeat (10) begin
            @(negedge clock_100k);
            if (ack_out) n_ack++;
        end
        check_eq("full_noack", n_ack, 0);
        dequeue_in = 1'b1;
        @(negedge clock_100k);
        dequeue_in = 1'b0;
        check_eq("full_pop", data_out, 8'h01);
        acked = 1'b0;
        for (int i = 0; i < 10 && !acked; i++) begin
            @(negedge clock_100k);
            if (ack_out) acked = 1'b1;
        end
        check_eq("ninth_ack", acked, 1);
        enqueue_in = 1'b0;
        repeat (2) @(negedge clock_100k);
        check_eq("ninth_len", len_out, DEPTH);

        // Drain all eight in order, then pop on empty.
        dequeue_in = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            @(negedge clock_100k);
            check_eq("drain_data",  data_out,  8'h02 + i);
            check_eq("drain_valid", valid_out, 1);
        end
        @(negedge clock_100k);
        dequeue_in = 1'b0;
        check_eq("empty_valid", valid_out, 0);
        check_eq("empty_data",  data_out,  8'h09);
        check_eq("empty_len",   len_out,   0);

        // Steady occupancy of 3 with simultaneous write and pop; 20 rounds wrap the pointers.
        for (int i = 0; i < 3; i++) send_byte(8'h30 + byte_t'(i), 0);
        for (int k = 0; k < 20; k++) begin
            data_in    = 8'h40 + byte_t'(k);
            enqueue_in = 1'b1;
            dequeue_in = 1'b1;
            @(negedge clock_100k);
            dequeue_in = 1'b0;
            enqueue_in = 1'b0;
            exp_b = (k < 3) ? 8'h30 + byte_t'(k) : 8'h40 + byte_t'(k - 3);
            check_eq("wrap_len",  len_out,  3);
            check_eq("wrap_ack",  ack_out,  1);
            check_eq("wrap_data", data_out, exp_b);
            repeat (2) @(negedge clock_100k);
        end

        // Reset during ACK with two bytes queued; held byte is re-accepted once.
        drain_all();
        send_byte(8'h11, 0);
        send_byte(8'h22, 0);
        data_in    = 8'h5A;
        enqueue_in = 1'b1;
        @(negedge clock_100k);
        check_eq("pre_rst_ack", ack_out, 1);
        check_eq("pre_rst_len", len_out, 3);
        #2 reset = 1'b1;
        #1;
        check_eq("mid_rst_ack",   ack_out,   0);
        check_eq("mid_rst_len",   len_out,   0);
        check_eq("mid_rst_empty", empty_out, 1);
        @(negedge clock_100k);
        reset = 1'b0;
        n_ack = 0;
        repeat (8) begin
            @(negedge clock_100k);
            if (ack_out) n_ack++;
        end
        check_eq("rst_reack", n_ack, 1);
        check_eq("rst_relen", len_out, 1);
        enqueue_in = 1'b0;
        repeat (2) @(negedge clock_100k);

        // Random traffic: deserializer-style producer, random consumer.
        gap  = 0;
        hold = 0;
        acked = 1'b0;
        for (int c = 0; c < 500; c++) begin
            @(negedge clock_100k);
            dequeue_in = ($urandom_range(0, 99) < 40);
            if (enqueue_in) begin
                if (acked || ack_out) begin
                    acked = 1'b1;
                    if (hold == 0) begin
                        enqueue_in = 1'b0;
                        acked = 1'b0;
                        gap = 2 + $urandom_range(0, 3);
                    end else begin
                        hold--;
                    end
                end
            end else if (gap > 0) begin
                gap--;
            end else if ($urandom_range(0, 1) == 1) begin
                data_in    = byte_t'($urandom);
                enqueue_in = 1'b1;
                hold       = $urandom_range(0, 3);
            end
        end
        enqueue_in = 1'b0;
        dequeue_in = 1'b0;
        repeat (3) @(negedge clock_100k);
        mon_en = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
